// File: rtl/sub_nibble_seq.sv
// sub_nibble_seq
// Sequential NBIT-wide subtractor that computes i_a - i_b - i_bw one 4-bit
// nibble per clock, least significant nibble first. The borrow travels
// between nibbles as an inverted carry held in a register, so the adder is
// only four bits wide whatever NBIT is.
//
// Ports
//   i_clk    : clock, every state update is on the rising edge
//   i_rstn   : asynchronous active-low reset
//   i_valid  : operands valid (accepted while o_ready is high)
//   o_ready  : block idle and able to accept operands
//   i_a      : minuend, NBIT bits
//   i_b      : subtrahend, NBIT bits
//   i_bw     : borrow in
//   o_valid  : result valid, held until i_ready
//   i_ready  : downstream accepts the result
//   o_d      : difference modulo 2^NBIT
//   o_bw     : borrow out, 1 when i_a < i_b + i_bw (unsigned)
//   o_z      : 1 when o_d is zero
//
// NBIT must be a multiple of 4 and at least 4.
module sub_nibble_seq #(
  parameter int NBIT = 32
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [NBIT-1:0] i_a,
  input  logic [NBIT-1:0] i_b,
  input  logic            i_bw,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [NBIT-1:0] o_d,
  output logic            o_bw,
  output logic            o_z
);

  localparam int NNIB = NBIT / 4;
  // A single-nibble build still needs a one-bit counter to keep the ports legal.
  localparam int CW = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NNIB - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [NBIT-1:0]   a_sh_r;
  logic [NBIT-1:0]   b_sh_r;
  logic [NBIT-1:0]   res_r;
  logic [CW-1:0]     cnt_r;
  logic              c_r;
  logic              ready_r;
  logic              valid_r;

  logic [NBIT-1:0]   a_sh_nx_s;
  logic [NBIT-1:0]   b_sh_nx_s;
  logic [NBIT-1:0]   res_nx_s;
  logic [NBIT-1:0]   res_ins_s;
  logic [CW-1:0]     cnt_nx_s;
  logic              c_nx_s;
  logic [NBIT-1:0]   d_nx_s;
  logic              bw_nx_s;
  logic              z_nx_s;
  logic [4:0]        sum_s;

  // Handshake outputs come straight from registers that mirror the state.
  assign o_ready = ready_r;
  assign o_valid = valid_r;

  // One nibble of a + ~b + carry; the carry is the inverted running borrow.
  always_comb begin
    sum_s = {1'b0, a_sh_r[3:0]} + {1'b0, ~b_sh_r[3:0]} + {4'b0000, c_r};
  end

  // Result register shifted down one nibble with the new nibble inserted on top.
  always_comb begin
    res_ins_s = res_r >> 3'd4;
    res_ins_s[NBIT-1 -: 4] = sum_s[3:0];
  end

  // Next-state and datapath decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nx_s = state_r;
    a_sh_nx_s  = a_sh_r;
    b_sh_nx_s  = b_sh_r;
    res_nx_s   = res_r;
    cnt_nx_s   = cnt_r;
    c_nx_s     = c_r;
    d_nx_s     = o_d;
    bw_nx_s    = o_bw;
    z_nx_s     = o_z;
    case (state_r)
      IDLE: begin
        if (i_valid) begin
          a_sh_nx_s  = i_a;
          b_sh_nx_s  = i_b;
          c_nx_s     = ~i_bw;
          cnt_nx_s   = {CW{1'b0}};
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        a_sh_nx_s = a_sh_r >> 3'd4;
        b_sh_nx_s = b_sh_r >> 3'd4;
        res_nx_s  = res_ins_s;
        c_nx_s    = sum_s[4];
        cnt_nx_s  = cnt_r + CNT_ONE;
        if (cnt_r == LAST_NIB) begin
          d_nx_s     = res_ins_s;
          bw_nx_s    = ~sum_s[4];
          z_nx_s     = (res_ins_s == {NBIT{1'b0}});
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= IDLE;
      a_sh_r  <= {NBIT{1'b0}};
      b_sh_r  <= {NBIT{1'b0}};
      res_r   <= {NBIT{1'b0}};
      cnt_r   <= {CW{1'b0}};
      c_r     <= 1'b0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      o_d     <= {NBIT{1'b0}};
      o_bw    <= 1'b0;
      o_z     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      a_sh_r  <= a_sh_nx_s;
      b_sh_r  <= b_sh_nx_s;
      res_r   <= res_nx_s;
      cnt_r   <= cnt_nx_s;
      c_r     <= c_nx_s;
      ready_r <= (state_nx_s == IDLE);
      valid_r <= (state_nx_s == DONE);
      o_d     <= d_nx_s;
      o_bw    <= bw_nx_s;
      o_z     <= z_nx_s;
    end
  end

endmodule

// File: tb/tb_sub_nibble_seq.sv
// Bench for sub_nibble_seq: three instances (NBIT = 32, 4, 8) share one
// stimulus stream. A transaction-level model computes each result from
// plain arithmetic at the accept edge and a negedge compare process checks
// handshake, latency, result and hold behaviour of every instance each cycle.
module tb_sub_nibble_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid = 1'b0;
  logic        ready = 1'b1;
  logic        bw = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;

  always #5 clk = ~clk;

  logic        rdy32, vld32, bw32, z32;
  logic [31:0] d32;
  logic        rdy4, vld4, bw4, z4;
  logic [3:0]  d4;
  logic        rdy8, vld8, bw8, z8;
  logic [7:0]  d8;

  sub_nibble_seq #(.NBIT(32)) u_dut32 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .o_ready(rdy32),
    .i_a(a), .i_b(b), .i_bw(bw), .o_valid(vld32), .i_ready(ready),
    .o_d(d32), .o_bw(bw32), .o_z(z32)
  );

  sub_nibble_seq #(.NBIT(4)) u_dut4 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .o_ready(rdy4),
    .i_a(a[3:0]), .i_b(b[3:0]), .i_bw(bw), .o_valid(vld4), .i_ready(ready),
    .o_d(d4), .o_bw(bw4), .o_z(z4)
  );

  sub_nibble_seq #(.NBIT(8)) u_dut8 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .o_ready(rdy8),
    .i_a(a[7:0]), .i_b(b[7:0]), .i_bw(bw), .o_valid(vld8), .i_ready(ready),
    .o_d(d8), .o_bw(bw8), .o_z(z8)
  );

  logic        ov[3];
  logic        ordy[3];
  logic        obw[3];
  logic        oz[3];
  logic [31:0] od[3];
  assign ov[0] = vld32;  assign ordy[0] = rdy32; assign obw[0] = bw32; assign oz[0] = z32;
  assign ov[1] = vld4;   assign ordy[1] = rdy4;  assign obw[1] = bw4;  assign oz[1] = z4;
  assign ov[2] = vld8;   assign ordy[2] = rdy8;  assign obw[2] = bw8;  assign oz[2] = z8;
  assign od[0] = d32;
  assign od[1] = {28'd0, d4};
  assign od[2] = {24'd0, d8};

  int nvec = 0;
  int nerr = 0;

  // nibble count and width of instance k
  function automatic int nn(input int k);
    case (k)
      0:       return 8;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int wd(input int k);
    return nn(k) * 4;
  endfunction

  // {borrow, difference} = a - b - bw over w bits, done in 64-bit arithmetic
  function automatic logic [31:0] model_d(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input int w);
    logic [63:0] m;
    logic [63:0] t;
    m = (64'd1 << w) - 64'd1;
    t = {32'd0, x} - {32'd0, y} - {63'd0, c};
    return t[31:0] & m[31:0];
  endfunction

  function automatic logic model_bw(input logic [31:0] x, input logic [31:0] y,
                                    input logic c, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return (({32'd0, x} & m) < (({32'd0, y} & m) + {63'd0, c}));
  endfunction

  // transaction model state, owned by the model process
  logic        pend[3];
  int          since[3];
  logic [31:0] exp_d[3];
  logic        exp_bw[3];
  logic        exp_z[3];
  logic [31:0] last_d[3];
  logic        last_bw[3];
  logic        last_z[3];
  int          done_cnt[3];

  // literal pins for the 32-bit instance, owned by the driver
  logic        lit_on = 1'b0;
  logic [31:0] lit_d = 32'd0;
  logic        lit_bw = 1'b0;
  logic        lit_z = 1'b0;

  // Model: accept when idle and i_valid, result due NNIB edges later,
  // retire on the first edge with i_ready once due.
  initial begin
    for (int k = 0; k < 3; k++) done_cnt[k] = 0;
    forever begin
      @(posedge clk or negedge rstn);
      for (int k = 0; k < 3; k++) begin
        if (!rstn) begin
          pend[k] = 1'b0; since[k] = 0;
          exp_d[k] = 32'd0; exp_bw[k] = 1'b0; exp_z[k] = 1'b0;
          last_d[k] = 32'd0; last_bw[k] = 1'b0; last_z[k] = 1'b0;
        end else if (pend[k]) begin
          if (since[k] >= nn(k) && ready) begin
            pend[k] = 1'b0;
            last_d[k] = exp_d[k]; last_bw[k] = exp_bw[k]; last_z[k] = exp_z[k];
            done_cnt[k] = done_cnt[k] + 1;
          end else begin
            since[k] = since[k] + 1;
          end
        end else if (valid) begin
          pend[k] = 1'b1;
          since[k] = 0;
          exp_d[k] = model_d(a, b, bw, wd(k));
          exp_bw[k] = model_bw(a, b, bw, wd(k));
          exp_z[k] = (exp_d[k] == 32'd0);
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s w%0d @%0t: got %h expected %h", nm, wd(k), $time, act, expv);
    end
  endtask

  logic seen[3];

  // Compare process: every falling edge, every instance.
  initial begin
    for (int k = 0; k < 3; k++) seen[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (pend[k]) begin
          chk("valid", k, {31'd0, ov[k]}, {31'd0, since[k] >= nn(k)});
          chk("ready_busy", k, {31'd0, ordy[k]}, 32'd0);
          if (since[k] >= nn(k)) begin
            chk("d", k, od[k], exp_d[k]);
            chk("bw", k, {31'd0, obw[k]}, {31'd0, exp_bw[k]});
            chk("z", k, {31'd0, oz[k]}, {31'd0, exp_z[k]});
            if (!seen[k] && k == 0 && lit_on) begin
              chk("lit_d", k, od[k], lit_d);
              chk("lit_bw", k, {31'd0, obw[k]}, {31'd0, lit_bw});
              chk("lit_z", k, {31'd0, oz[k]}, {31'd0, lit_z});
              chk("model_lit_d", k, exp_d[k], lit_d);
              chk("model_lit_bw", k, {31'd0, exp_bw[k]}, {31'd0, lit_bw});
            end
            seen[k] = 1'b1;
          end else begin
            chk("hold_run_d", k, od[k], last_d[k]);
            chk("hold_run_bw", k, {31'd0, obw[k]}, {31'd0, last_bw[k]});
          end
        end else begin
          seen[k] = 1'b0;
          chk("valid_idle", k, {31'd0, ov[k]}, 32'd0);
          chk("ready_idle", k, {31'd0, ordy[k]}, 32'd1);
          chk("hold_d", k, od[k], last_d[k]);
          chk("hold_bw", k, {31'd0, obw[k]}, {31'd0, last_bw[k]});
          chk("hold_z", k, {31'd0, oz[k]}, {31'd0, last_z[k]});
        end
      end
    end
  end

  task automatic wait_idle32();
    for (int n = 0; n < 40 && pend[0]; n++) @(negedge clk);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic tbw,
                        input logic [31:0] ld, input logic lbw, input logic lz);
    lit_d = ld; lit_bw = lbw; lit_z = lz; lit_on = 1'b1;
    wait_idle32();
    a = ta; b = tbv; bw = tbw; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_idle32();
    lit_on = 1'b0;
  endtask

  initial begin
    int target;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0);
    run_op(32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // backpressure: result held for 10 cycles while inputs churn
    wait_idle32();
    lit_d = 32'h0000_000F; lit_bw = 1'b0; lit_z = 1'b0; lit_on = 1'b1;
    ready = 1'b0;
    a = 32'h0000_0010; b = 32'h0000_0001; bw = 1'b0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (8) @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      valid = ~valid;
      a = $urandom;
      b = $urandom;
      bw = ~bw;
    end
    valid = 1'b0;
    ready = 1'b1;
    wait_idle32();
    lit_on = 1'b0;
    @(negedge clk);

    // reset in the middle of RUN, just after E3
    wait_idle32();
    a = 32'hAAAA_AAAA; b = 32'h1234_5678; bw = 1'b0; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // random traffic with random handshake gaps on both sides
    target = done_cnt[0] + 2000;
    for (int c = 0; c < 50000 && done_cnt[0] < target; c++) begin
      @(negedge clk);
      valid = ($urandom_range(0, 1) == 1);
      ready = ($urandom_range(0, 3) != 0);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      bw = ($urandom_range(0, 1) == 1);
    end
    valid = 1'b0;
    ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
